// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arith/move results, HI/LO registers,
// and a 32-step restoring divider that stalls the pipeline while it runs.
module ex_stage #(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  HILO_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       ex_i_alu_op,
    input  logic [2:0]       ex_i_alu_sel,
    input  logic [WIDTH-1:0] ex_i_reg0,
    input  logic [WIDTH-1:0] ex_i_reg1,
    input  logic [4:0]       ex_i_waddr,
    input  logic             ex_i_wreg,
    input  logic             flush,
    output logic             ex_o_wreg,
    output logic [4:0]       ex_o_waddr,
    output logic [WIDTH-1:0] ex_o_wdata,
    output logic             stall_req
);

    localparam int unsigned CNT_W = 5;

    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
    localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
    localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
    localparam logic [7:0] EXE_MFHI_OP = 8'b0001_0000;
    localparam logic [7:0] EXE_MFLO_OP = 8'b0001_0010;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    div_state_t             state;
    logic [CNT_W-1:0]       count;
    logic [WIDTH-1:0]       quo;
    logic [WIDTH-1:0]       rem;
    logic [WIDTH-1:0]       dvs;
    logic                   neg_q;
    logic                   neg_r;
    logic [WIDTH-1:0]       hi;
    logic [WIDTH-1:0]       lo;

    logic                   is_sdiv;
    logic                   is_div;
    logic [WIDTH-1:0]       abs0;
    logic [WIDTH-1:0]       abs1;
    logic [WIDTH:0]         shifted;
    logic [WIDTH:0]         diff;
    logic                   ge;
    logic [4:0]             shamt;

    assign is_sdiv = (ex_i_alu_op == EXE_DIV_OP);
    assign is_div  = is_sdiv || (ex_i_alu_op == EXE_DIVU_OP);
    assign abs0    = ex_i_reg0[WIDTH-1] ? (WIDTH'(0) - ex_i_reg0) : ex_i_reg0;
    assign abs1    = ex_i_reg1[WIDTH-1] ? (WIDTH'(0) - ex_i_reg1) : ex_i_reg1;
    assign shamt   = ex_i_reg0[4:0];

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};
    assign ge      = ~diff[WIDTH];

    // Divider FSM and HI/LO; operands are sampled only in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= HILO_RST;
            lo    <= HILO_RST;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (is_div) begin
                        count <= '0;
                        if (ex_i_reg1 == '0) begin
                            quo   <= '1;
                            rem   <= ex_i_reg0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= DONE;
                        end else begin
                            quo   <= is_sdiv ? abs0 : ex_i_reg0;
                            dvs   <= is_sdiv ? abs1 : ex_i_reg1;
                            rem   <= '0;
                            neg_q <= is_sdiv & (ex_i_reg0[WIDTH-1] ^ ex_i_reg1[WIDTH-1]);
                            neg_r <= is_sdiv & ex_i_reg0[WIDTH-1];
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    quo   <= {quo[WIDTH-2:0], ge};
                    rem   <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    lo    <= neg_q ? (WIDTH'(0) - quo) : quo;
                    hi    <= neg_r ? (WIDTH'(0) - rem) : rem;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result mux, write-enable gating and stall request.
    always_comb begin
        ex_o_wreg  = 1'b0;
        ex_o_waddr = '0;
        ex_o_wdata = '0;
        stall_req  = 1'b0;
        if (!rst) begin
            ex_o_waddr = ex_i_waddr;
            ex_o_wreg  = is_div ? 1'b0 : ex_i_wreg;
            case (ex_i_alu_sel)
                EXE_RES_LOGIC: begin
                    case (ex_i_alu_op)
                        EXE_OR_OP:  ex_o_wdata = ex_i_reg0 | ex_i_reg1;
                        EXE_AND_OP: ex_o_wdata = ex_i_reg0 & ex_i_reg1;
                        EXE_XOR_OP: ex_o_wdata = ex_i_reg0 ^ ex_i_reg1;
                        EXE_NOR_OP: ex_o_wdata = ~(ex_i_reg0 | ex_i_reg1);
                        default:    ex_o_wdata = '0;
                    endcase
                end
                EXE_RES_SHIFT: begin
                    case (ex_i_alu_op)
                        EXE_SLL_OP: ex_o_wdata = ex_i_reg1 << shamt;
                        EXE_SRL_OP: ex_o_wdata = ex_i_reg1 >> shamt;
                        EXE_SRA_OP: ex_o_wdata = WIDTH'($signed(ex_i_reg1) >>> shamt);
                        default:    ex_o_wdata = '0;
                    endcase
                end
                EXE_RES_ARITH: begin
                    case (ex_i_alu_op)
                        EXE_ADDU_OP: ex_o_wdata = ex_i_reg0 + ex_i_reg1;
                        EXE_SUBU_OP: ex_o_wdata = ex_i_reg0 - ex_i_reg1;
                        EXE_SLT_OP:  ex_o_wdata = WIDTH'($signed(ex_i_reg0) < $signed(ex_i_reg1));
                        EXE_SLTU_OP: ex_o_wdata = WIDTH'(ex_i_reg0 < ex_i_reg1);
                        default:     ex_o_wdata = '0;
                    endcase
                end
                EXE_RES_MOVE: begin
                    case (ex_i_alu_op)
                        EXE_MFHI_OP: ex_o_wdata = hi;
                        EXE_MFLO_OP: ex_o_wdata = lo;
                        default:     ex_o_wdata = '0;
                    endcase
                end
                default: ex_o_wdata = '0;
            endcase
            if (!flush) begin
                case (state)
                    IDLE:    stall_req = is_div;
                    BUSY:    stall_req = 1'b1;
                    default: stall_req = 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_ex_stage;

    localparam logic [7:0] OP_AND  = 8'b0010_0100;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110;
    localparam logic [7:0] OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100;
    localparam logic [7:0] OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_SLT  = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU = 8'b0010_1011;
    localparam logic [7:0] OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] OP_SUBU = 8'b0010_0011;
    localparam logic [7:0] OP_MFHI = 8'b0001_0000;
    localparam logic [7:0] OP_MFLO = 8'b0001_0010;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;
    localparam logic [2:0] SEL_ARITH = 3'b100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  alu_op = '0;
    logic [2:0]  alu_sel = '0;
    logic [31:0] reg0 = '0;
    logic [31:0] reg1 = '0;
    logic [4:0]  waddr = '0;
    logic        wreg = 1'b0;
    logic        flush = 1'b0;
    logic        o_wreg;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;
    logic        o_stall;

    typedef struct {
        string       name;
        logic [31:0] wdata;
        logic [4:0]  waddr;
        logic        wreg;
        logic        stall;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    ex_stage #(.WIDTH(32), .HILO_RST(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_i_alu_op  (alu_op),
        .ex_i_alu_sel (alu_sel),
        .ex_i_reg0    (reg0),
        .ex_i_reg1    (reg1),
        .ex_i_waddr   (waddr),
        .ex_i_wreg    (wreg),
        .flush        (flush),
        .ex_o_wreg    (o_wreg),
        .ex_o_waddr   (o_waddr),
        .ex_o_wdata   (o_wdata),
        .stall_req    (o_stall)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and push the outputs expected for that cycle.
    task automatic step(input logic r, input logic fl, input logic [2:0] sel,
                        input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input logic we, input logic [31:0] ed,
                        input logic [4:0] ewa, input logic ewe, input logic es,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; flush = fl; alu_sel = sel; alu_op = op;
        reg0 = a; reg1 = b; waddr = wa; wreg = we;
        e.name = nm; e.wdata = ed; e.waddr = ewa; e.wreg = ewe; e.stall = es;
        exp_q.push_back(e);
    endtask

    task automatic op1(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wa, input logic [31:0] ed,
                       input string nm);
        step(1'b0, 1'b0, sel, op, a, b, wa, 1'b1, ed, wa, 1'b1, 1'b0, nm);
    endtask

    // A full divide: n_stall cycles with stall high, then the DONE cycle.
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int n_stall, input string nm);
        for (int i = 0; i < n_stall; i++)
            step(1'b0, 1'b0, SEL_NOP, op, a, b, 5'd4, 1'b1, 32'h0, 5'd4, 1'b0, 1'b1, nm);
        step(1'b0, 1'b0, SEL_NOP, op, a, b, 5'd4, 1'b1, 32'h0, 5'd4, 1'b0, 1'b0, {nm, "_done"});
    endtask

    task automatic read_hilo(input logic [31:0] elo, input logic [31:0] ehi, input string nm);
        op1(SEL_MOVE, OP_MFLO, 32'h0, 32'h0, 5'd6, elo, {nm, "_lo"});
        op1(SEL_MOVE, OP_MFHI, 32'h0, 32'h0, 5'd7, ehi, {nm, "_hi"});
    endtask

    // Monitor: compare whatever expectation is pending for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (o_wdata !== e.wdata || o_waddr !== e.waddr ||
                    o_wreg !== e.wreg || o_stall !== e.stall) begin
                    errors++;
                    $display("FAIL %s: got wdata=%h waddr=%0d wreg=%b stall=%b, want wdata=%h waddr=%0d wreg=%b stall=%b",
                             e.name, o_wdata, o_waddr, o_wreg, o_stall,
                             e.wdata, e.waddr, e.wreg, e.stall);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset holds outputs at zero regardless of inputs.
        step(1'b1, 1'b0, SEL_LOGIC, OP_OR, 32'h0000_1234, 32'hFF00_0000, 5'd3, 1'b1,
             32'h0, 5'd0, 1'b0, 1'b0, "reset0");
        step(1'b1, 1'b0, SEL_LOGIC, OP_OR, 32'h0000_1234, 32'hFF00_0000, 5'd3, 1'b1,
             32'h0, 5'd0, 1'b0, 1'b0, "reset1");

        op1(SEL_LOGIC, OP_OR,   32'h0000_1234, 32'hFF00_0000, 5'd3, 32'hFF00_1234, "ori");
        op1(SEL_LOGIC, OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd5, 32'hF000_F000, "and");
        op1(SEL_LOGIC, OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd5, 32'h0FF0_0FF0, "xor");
        op1(SEL_LOGIC, OP_NOR,  32'h0000_0000, 32'h0000_0000, 5'd5, 32'hFFFF_FFFF, "nor");
        op1(SEL_SHIFT, OP_SLL,  32'h0000_0004, 32'h0000_0001, 5'd8, 32'h0000_0010, "sll");
        op1(SEL_SHIFT, OP_SRL,  32'h0000_0004, 32'h8000_0000, 5'd8, 32'h0800_0000, "srl");
        op1(SEL_SHIFT, OP_SRA,  32'h0000_0004, 32'h8000_0000, 5'd8, 32'hF800_0000, "sra");
        op1(SEL_SHIFT, OP_SRA,  32'hFFFF_FFE1, 32'h4000_0000, 5'd8, 32'h2000_0000, "sra_amt5");
        op1(SEL_ARITH, OP_ADDU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd9, 32'h0000_0001, "addu_wrap");
        op1(SEL_ARITH, OP_SUBU, 32'h0000_0001, 32'h0000_0002, 5'd9, 32'hFFFF_FFFF, "subu_wrap");
        op1(SEL_ARITH, OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 5'd9, 32'h0000_0001, "slt");
        op1(SEL_ARITH, OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd9, 32'h0000_0000, "sltu");
        op1(3'b111,    OP_OR,   32'h1234_5678, 32'h0000_0001, 5'd10, 32'h0000_0000, "bad_sel");
        read_hilo(32'h0, 32'h0, "hilo_reset");

        run_div(OP_DIVU, 32'd100, 32'd7, 33, "divu100_7");
        read_hilo(32'd14, 32'd2, "divu100_7");

        run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, "div_m7_2");
        read_hilo(32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2");

        run_div(OP_DIV, 32'd5, 32'd0, 1, "div_by0");
        read_hilo(32'hFFFF_FFFF, 32'd5, "div_by0");

        run_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, "div_min_m1");
        read_hilo(32'h8000_0000, 32'h0, "div_min_m1");

        // Flush at BUSY count 10: no commit, HI/LO keep previous result.
        for (int i = 0; i < 11; i++)
            step(1'b0, 1'b0, SEL_NOP, OP_DIVU, 32'd100, 32'd7, 5'd4, 1'b1,
                 32'h0, 5'd4, 1'b0, 1'b1, "flush_pre");
        step(1'b0, 1'b1, SEL_NOP, OP_DIVU, 32'd100, 32'd7, 5'd4, 1'b1,
             32'h0, 5'd4, 1'b0, 1'b0, "flush_cyc");
        read_hilo(32'h8000_0000, 32'h0, "after_flush");

        // Reset mid-BUSY: outputs zero, HI/LO back to reset value.
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b0, SEL_NOP, OP_DIVU, 32'd100, 32'd7, 5'd4, 1'b1,
                 32'h0, 5'd4, 1'b0, 1'b1, "rst_pre");
        step(1'b1, 1'b0, SEL_NOP, OP_DIVU, 32'd100, 32'd7, 5'd4, 1'b1,
             32'h0, 5'd0, 1'b0, 1'b0, "rst_mid");
        read_hilo(32'h0, 32'h0, "after_rst");

        // Back-to-back divides: second restarts cleanly from IDLE.
        run_div(OP_DIVU, 32'd100, 32'd7, 33, "b2b_first");
        run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, "b2b_second");
        read_hilo(32'hFFFF_FFFD, 32'hFFFF_FFFF, "b2b");

        // Let the monitor drain; a leftover expectation counts as a failure.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
